// File: rtl/demux16_lane_loader_if.sv
// Bus bundle for the 16-lane loader: sample/lane-select inputs, lane outputs and status.
interface demux16_lane_loader_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]    din;
    logic [3:0]          sel;
    logic                load;
    logic                auto_en;
    logic                clr;
    logic [16*WIDTH-1:0] dout;
    logic [15:0]         lane_valid;
    logic [3:0]          cur_lane;
    logic                frame_done;
    logic                full;

    modport master (
        output din, sel, load, auto_en, clr,
        input  dout, lane_valid, cur_lane, frame_done, full
    );

    modport slave (
        input  din, sel, load, auto_en, clr,
        output dout, lane_valid, cur_lane, frame_done, full
    );
endinterface

// File: rtl/demux16_lane_loader.sv
// 1-to-16 registered demultiplexer with occupancy tracking and frame-complete pulse.
//
// state    | meaning
// ---------+----------------------------------------------------------
// EMPTY    | no lane written since reset/clear
// FILLING  | some lanes written, frame not yet complete
// FULL     | all 16 lanes valid; manual loads overwrite, auto load restarts
module demux16_lane_loader #(
    parameter int WIDTH = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    demux16_lane_loader_if.slave bus
);
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic [16*WIDTH-1:0] dout_q,       dout_d;
    logic [15:0]         lane_valid_q, lane_valid_d;
    logic [3:0]          cur_lane_q,   cur_lane_d;
    logic                frame_done_q, frame_done_d;
    logic                full_q,       full_d;

    logic [3:0]          lane_sel;
    logic [15:0]         lane_onehot;
    logic [15:0]         valid_merged;

    // Target lane: round-robin counter in auto mode, explicit select otherwise.
    always_comb begin
        lane_sel     = bus.auto_en ? cur_lane_q : bus.sel;
        lane_onehot  = 16'(1) << lane_sel;
        valid_merged = lane_valid_q | lane_onehot;
    end

    // Next-state: clear dominates load; FULL handles auto restart vs manual overwrite.
    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        lane_valid_d = lane_valid_q;
        cur_lane_d   = cur_lane_q;
        frame_done_d = 1'b0;

        if (bus.clr) begin
            state_d      = ST_EMPTY;
            lane_valid_d = 16'h0000;
            cur_lane_d   = 4'd0;
        end else if (bus.load) begin
            dout_d[int'(lane_sel)*WIDTH +: WIDTH] = bus.din;
            if (bus.auto_en) begin
                cur_lane_d = cur_lane_q + 4'd1;
            end
            case (state_q)
                ST_EMPTY, ST_FILLING: begin
                    lane_valid_d = valid_merged;
                    if (&valid_merged) begin
                        state_d      = ST_FULL;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_FILLING;
                    end
                end
                ST_FULL: begin
                    if (bus.auto_en) begin
                        lane_valid_d = lane_onehot;
                        state_d      = ST_FILLING;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    lane_valid_d = 16'h0000;
                end
            endcase
        end
        full_d = (state_d == ST_FULL);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            dout_q       <= '0;
            lane_valid_q <= 16'h0000;
            cur_lane_q   <= 4'd0;
            frame_done_q <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            lane_valid_q <= lane_valid_d;
            cur_lane_q   <= cur_lane_d;
            frame_done_q <= frame_done_d;
            full_q       <= full_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.lane_valid = lane_valid_q;
    assign bus.cur_lane   = cur_lane_q;
    assign bus.frame_done = frame_done_q;
    assign bus.full       = full_q;
endmodule

// File: tb/tb_demux16_lane_loader.sv
// Scoreboard bench for demux16_lane_loader (WIDTH=8): driver pushes model results, monitor compares.
module tb_demux16_lane_loader;
    localparam int W = 8;

    typedef struct {
        logic [16*W-1:0] dout;
        logic [15:0]     lv;
        logic [3:0]      cur;
        logic            fd;
        logic            full;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    // Reference model: plain arrays and counters
    logic [W-1:0] m_lane[16];
    bit           m_written[16];
    int           m_ctr;
    bit           m_full;
    bit           m_pulse;

    demux16_lane_loader_if #(.WIDTH(W)) bus();

    demux16_lane_loader #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [16*W-1:0] act, input logic [16*W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.dout = '0;
        e.lv   = '0;
        for (int k = 0; k < 16; k++) begin
            e.dout[k*W +: W] = m_lane[k];
            e.lv[k]          = m_written[k];
        end
        e.cur  = 4'(m_ctr);
        e.fd   = m_pulse;
        e.full = m_full;
        return e;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 16; k++) begin
            m_lane[k]    = '0;
            m_written[k] = 1'b0;
        end
        m_ctr   = 0;
        m_full  = 1'b0;
        m_pulse = 1'b0;
    endfunction

    function automatic void model_step(input bit c, input bit l, input bit a,
                                       input int s, input logic [W-1:0] d);
        int lane;
        int nvalid;
        m_pulse = 1'b0;
        if (c) begin
            for (int k = 0; k < 16; k++) m_written[k] = 1'b0;
            m_ctr  = 0;
            m_full = 1'b0;
        end else if (l) begin
            lane         = a ? m_ctr : s;
            m_lane[lane] = d;
            if (a) m_ctr = (m_ctr + 1) % 16;
            if (m_full && a) begin
                for (int k = 0; k < 16; k++) m_written[k] = (k == lane);
                m_full = 1'b0;
            end else if (!m_full) begin
                m_written[lane] = 1'b1;
                nvalid = 0;
                for (int k = 0; k < 16; k++) nvalid += int'(m_written[k]);
                if (nvalid == 16) begin
                    m_full  = 1'b1;
                    m_pulse = 1'b1;
                end
            end
        end
    endfunction

    // Drive one cycle of stimulus and queue the expected post-edge outputs.
    task automatic drive(input bit c, input bit l, input bit a, input int s, input logic [W-1:0] d);
        @(negedge clk);
        bus.clr     = c;
        bus.load    = l;
        bus.auto_en = a;
        bus.sel     = 4'(s);
        bus.din     = d;
        model_step(c, l, a, s, d);
        exp_q.push_back(snapshot());
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, '0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic async_reset();
        @(negedge clk);
        bus.load = 1'b0;
        bus.clr  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_dout",       bus.dout,       '0);
        chk("rst_lane_valid", bus.lane_valid, '0);
        chk("rst_cur_lane",   bus.cur_lane,   '0);
        chk("rst_frame_done", bus.frame_done, '0);
        chk("rst_full",       bus.full,       '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: outputs are presented every cycle; compare against the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dout",       bus.dout,       e.dout);
            chk("lane_valid", bus.lane_valid, e.lv);
            chk("cur_lane",   bus.cur_lane,   e.cur);
            chk("frame_done", bus.frame_done, e.fd);
            chk("full",       bus.full,       e.full);
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.din     = '0;
        bus.sel     = '0;
        bus.load    = 1'b0;
        bus.auto_en = 1'b0;
        bus.clr     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Auto fill with a ramp, then observe the frame_done pulse.
        for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 1'b1, 0, 8'(8'h10 + k));
        idle();
        idle();

        // FULL: manual overwrite keeps FULL, auto load restarts the frame.
        drive(1'b0, 1'b1, 1'b0, 0, 8'h77);
        drive(1'b0, 1'b1, 1'b1, 0, 8'h3C);
        idle();

        // Manual sparse writes to the same lane.
        drive(1'b1, 1'b0, 1'b0, 0, '0);
        drive(1'b0, 1'b1, 1'b0, 3, 8'hA5);
        drive(1'b0, 1'b1, 1'b0, 3, 8'h5A);
        idle();

        // Clear colliding with a load: sample dropped.
        drive(1'b1, 1'b1, 1'b0, 2, 8'hFF);
        idle();

        // Mixed modes: 8 auto loads then manual lanes 8..15.
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 1'b1, 0, 8'(8'h40 + k));
        for (int k = 8; k < 16; k++) drive(1'b0, 1'b1, 1'b0, k, 8'(8'h80 + k));
        idle();
        idle();

        // Partial fill then asynchronous reset mid-frame.
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 1'b1, 0, 8'(8'hC0 + k));
        async_reset();
        idle();

        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 800; n++) begin
            bit c;
            bit l;
            bit a;
            c = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 2) != 0);
            drive(c, l, a, int'($urandom_range(0, 15)), 8'($urandom));
            if (n % 250 == 249) async_reset();
        end
        idle();

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
